// File: rtl/pet2001_pkg.sv
// Shared constants for the PET 2001 PRG loader: state codes, BASIC pointer offsets
// and the write tables used by the DMA sequencer. PRG_AUTORUN_EN adds the autorun entries.
package pet2001_pkg;

    localparam int unsigned HDR_LEN = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR_LO  = 3'd1;
    localparam state_t ST_HDR_HI  = 3'd2;
    localparam state_t ST_DATA    = 3'd3;
    localparam state_t ST_PATCH   = 3'd4;
    localparam state_t ST_DONE    = 3'd5;
`ifdef PRG_AUTORUN_EN
    localparam state_t ST_AUTORUN = 3'd6;
`endif

    localparam logic [15:0] OFS_VARTAB = 16'd0;
    localparam logic [15:0] OFS_ARYTAB = 16'd2;
    localparam logic [15:0] OFS_STREND = 16'd4;

    localparam logic [3:0] SEQ_PATCH_FIRST = 4'd0;
    localparam logic [3:0] SEQ_PATCH_LAST  = 4'd5;

`ifdef PRG_AUTORUN_EN
    localparam logic [15:0] KBUF_ADDR     = 16'h026F;
    localparam logic [15:0] KBUF_CNT_ADDR = 16'h009E;

    localparam logic [7:0] AR_R     = 8'h52;
    localparam logic [7:0] AR_U     = 8'h55;
    localparam logic [7:0] AR_N     = 8'h4E;
    localparam logic [7:0] AR_CR    = 8'h0D;
    localparam logic [7:0] AR_COUNT = 8'h04;

    localparam logic [3:0] SEQ_AUTO_FIRST = 4'd6;
    localparam logic [3:0] SEQ_AUTO_LAST  = 4'd10;

    function automatic logic [7:0] autorun_byte(input logic [3:0] idx);
        case (idx)
            4'd6:    return AR_R;
            4'd7:    return AR_U;
            4'd8:    return AR_N;
            4'd9:    return AR_CR;
            default: return AR_COUNT;
        endcase
    endfunction
`endif

    // Entries 0..5 are VARTAB/ARYTAB/STREND, each lo byte then hi byte.
    function automatic logic [15:0] ptr_offset(input logic [2:0] idx);
        logic [15:0] base;
        case (idx[2:1])
            2'd0:    base = OFS_VARTAB;
            2'd1:    base = OFS_ARYTAB;
            default: base = OFS_STREND;
        endcase
        return base + {15'd0, idx[0]};
    endfunction

endpackage

// File: rtl/pet2001_dma_seq.sv
// Table-driven DMA write sequencer: walks entries first_idx..last_idx, one write every
// two cycles, then pulses done. Autorun entries exist only with PRG_AUTORUN_EN.
module pet2001_dma_seq
    import pet2001_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h002A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  first_idx,
    input  logic [3:0]  last_idx,
    input  logic [15:0] ptr_val,
    output logic [15:0] addr,
    output logic [7:0]  din,
    output logic        we,
    output logic        done
);

    logic [3:0]  idx;
    logic        run;
    logic        gap;
    logic [15:0] tbl_addr;
    logic [7:0]  tbl_data;

    always_comb begin
        tbl_addr = BASE_ADDR + ptr_offset(idx[2:0]);
        tbl_data = idx[0] ? ptr_val[15:8] : ptr_val[7:0];
`ifdef PRG_AUTORUN_EN
        if (idx >= SEQ_AUTO_FIRST) begin
            tbl_addr = (idx == SEQ_AUTO_LAST) ? KBUF_CNT_ADDR
                                              : KBUF_ADDR + {12'd0, idx - SEQ_AUTO_FIRST};
            tbl_data = autorun_byte(idx);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            run  <= 1'b0;
            gap  <= 1'b0;
            addr <= '0;
            din  <= '0;
            we   <= 1'b0;
            done <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            if (!run) begin
                if (start) begin
                    idx <= first_idx;
                    run <= 1'b1;
                    gap <= 1'b0;
                end
            end else if (!gap) begin
                addr <= tbl_addr;
                din  <= tbl_data;
                we   <= 1'b1;
                gap  <= 1'b1;
            end else begin
                gap <= 1'b0;
                if (idx == last_idx) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pet2001_prg_loader.sv
// Streams a MiSTer ioctl .PRG download into PET RAM over the DMA port, then patches the
// BASIC end-of-program pointers. Optional macro PRG_AUTORUN_EN also types RUN<CR>.
module pet2001_prg_loader
    import pet2001_pkg::*;
#(
    parameter logic [15:0] VARTAB_ADDR = 16'h002A,
    parameter logic [15:0] RAM_TOP     = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        err_short,
    output logic        err_ovf,
    output logic [15:0] end_addr
);

    state_t      state;
    logic        dl_q;
    logic [7:0]  load_lo;
    logic [16:0] wr_ptr;
    logic        data_we;
    logic [15:0] data_addr;
    logic [7:0]  data_din;

    logic        seq_start;
    logic [3:0]  seq_first;
    logic [3:0]  seq_last;
    logic [15:0] seq_addr;
    logic [7:0]  seq_din;
    logic        seq_we;
    logic        seq_done;

    logic        can_write;
    logic [16:0] wr_next;
    logic [15:0] end_next;
    logic [15:0] hdr_end;

    // wr_ptr saturates at bit 16: once it carries out, every later byte is dropped.
    always_comb begin
        can_write = (wr_ptr < {1'b0, RAM_TOP});
        wr_next   = wr_ptr + ((ioctl_wr && !wr_ptr[16]) ? 17'd1 : 17'd0);
        end_next  = (wr_next >= {1'b0, RAM_TOP}) ? RAM_TOP : wr_next[15:0];
        hdr_end   = ({ioctl_data, load_lo} >= RAM_TOP) ? RAM_TOP : {ioctl_data, load_lo};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dl_q      <= 1'b0;
            load_lo   <= '0;
            wr_ptr    <= '0;
            data_we   <= 1'b0;
            data_addr <= '0;
            data_din  <= '0;
            seq_start <= 1'b0;
            seq_first <= '0;
            seq_last  <= '0;
            err_short <= 1'b0;
            err_ovf   <= 1'b0;
            end_addr  <= '0;
        end else begin
            dl_q      <= ioctl_download;
            data_we   <= 1'b0;
            seq_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ioctl_download && !dl_q) begin
                        err_short <= 1'b0;
                        err_ovf   <= 1'b0;
                        state     <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (!ioctl_download) begin
                        err_short <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (ioctl_wr) begin
                        load_lo <= ioctl_data;
                        state   <= ST_HDR_HI;
                    end
                end
                ST_HDR_HI: begin
                    if (ioctl_wr) begin
                        wr_ptr <= {1'b0, ioctl_data, load_lo};
                        if (ioctl_download) begin
                            state <= ST_DATA;
                        end else begin
                            end_addr  <= hdr_end;
                            seq_start <= 1'b1;
                            seq_first <= SEQ_PATCH_FIRST;
                            seq_last  <= SEQ_PATCH_LAST;
                            state     <= ST_PATCH;
                        end
                    end else if (!ioctl_download) begin
                        err_short <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (ioctl_wr) begin
                        if (can_write) begin
                            data_addr <= wr_ptr[15:0];
                            data_din  <= ioctl_data;
                            data_we   <= 1'b1;
                        end else begin
                            err_ovf <= 1'b1;
                        end
                        wr_ptr <= wr_next;
                    end
                    // A strobe on the falling edge is committed above before patching.
                    if (!ioctl_download) begin
                        end_addr  <= end_next;
                        seq_start <= 1'b1;
                        seq_first <= SEQ_PATCH_FIRST;
                        seq_last  <= SEQ_PATCH_LAST;
                        state     <= ST_PATCH;
                    end
                end
                ST_PATCH: begin
                    if (seq_done) begin
`ifdef PRG_AUTORUN_EN
                        seq_start <= 1'b1;
                        seq_first <= SEQ_AUTO_FIRST;
                        seq_last  <= SEQ_AUTO_LAST;
                        state     <= ST_AUTORUN;
`else
                        state     <= ST_DONE;
`endif
                    end
                end
`ifdef PRG_AUTORUN_EN
                ST_AUTORUN: begin
                    if (seq_done) begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    pet2001_dma_seq #(
        .BASE_ADDR (VARTAB_ADDR)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .start     (seq_start),
        .first_idx (seq_first),
        .last_idx  (seq_last),
        .ptr_val   (end_addr),
        .addr      (seq_addr),
        .din       (seq_din),
        .we        (seq_we),
        .done      (seq_done)
    );

    always_comb begin
        dma_addr = seq_we ? seq_addr : data_addr;
        dma_din  = seq_we ? seq_din : data_din;
        // Final guard so no write can ever reach the ROM half of the map.
        dma_we   = (data_we | seq_we) & ~dma_addr[15];
        busy     = (state != ST_IDLE);
        cpu_hold = (state != ST_IDLE);
`ifdef PRG_AUTORUN_EN
        ioctl_wait = (state == ST_PATCH) || (state == ST_AUTORUN);
`else
        ioctl_wait = (state == ST_PATCH);
`endif
    end

endmodule

// File: tb/tb_pet2001_prg_loader.sv
// Self-checking bench for pet2001_prg_loader against a byte-level model of the
// PRG download rules; honours PRG_AUTORUN_EN when defined.
`timescale 1ns/1ps
module tb_pet2001_prg_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_data = 8'h00;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        cpu_hold;
    logic        busy;
    logic        err_short;
    logic        err_ovf;
    logic [15:0] end_addr;

    pet2001_prg_loader #(
        .VARTAB_ADDR (16'h002A),
        .RAM_TOP     (16'h8000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .dma_addr       (dma_addr),
        .dma_din        (dma_din),
        .dma_we         (dma_we),
        .cpu_hold       (cpu_hold),
        .busy           (busy),
        .err_short      (err_short),
        .err_ovf        (err_ovf),
        .end_addr       (end_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [15:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          got_cyc[$];
    int          wait_cycles;

    always @(negedge clk) begin
        if (dma_we === 1'b1) begin
            got_addr.push_back(dma_addr);
            got_data.push_back(dma_din);
            got_cyc.push_back(cyc);
        end
        if (ioctl_wait === 1'b1) wait_cycles++;
    end

    logic [7:0]  stim[$];
    int          strobe_cyc[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          exp_cyc[$];
    int          exp_grp[$];
    bit          exp_ovf;
    bit          exp_short;
    logic [15:0] exp_end;
    logic [15:0] last_end = 16'h0000;

    // Reference: little-endian header, sequential data below 0x8000, then the pointer patch.
    function automatic void model_download();
        int ptr;
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete(); exp_grp.delete();
        exp_ovf = 0;
        if (stim.size() < 2) begin
            exp_short = 1;
            exp_end   = last_end;
            return;
        end
        exp_short = 0;
        ptr = {stim[1], stim[0]};
        for (int i = 2; i < stim.size(); i++) begin
            if (ptr < 'h8000) begin
                exp_addr.push_back(16'(ptr)); exp_data.push_back(stim[i]);
                exp_cyc.push_back(strobe_cyc[i] + 1); exp_grp.push_back(0);
            end else begin
                exp_ovf = 1;
            end
            ptr++;
        end
        exp_end = (ptr < 'h8000) ? 16'(ptr) : 16'h8000;
        for (int i = 0; i < 6; i++) begin
            exp_addr.push_back(16'h002A + 16'(i));
            exp_data.push_back((i % 2) ? exp_end[15:8] : exp_end[7:0]);
            exp_cyc.push_back(-1); exp_grp.push_back(1);
        end
`ifdef PRG_AUTORUN_EN
        begin
            logic [7:0] run_txt[5] = '{8'h52, 8'h55, 8'h4E, 8'h0D, 8'h04};
            for (int i = 0; i < 5; i++) begin
                exp_addr.push_back((i == 4) ? 16'h009E : 16'h026F + 16'(i));
                exp_data.push_back(run_txt[i]);
                exp_cyc.push_back(-1); exp_grp.push_back(2);
            end
        end
`endif
        last_end = exp_end;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input bit drop);
        @(posedge clk); #1;
        ioctl_wr   = 1'b1;
        ioctl_data = b;
        strobe_cyc.push_back(cyc);
        if (drop) ioctl_download = 1'b0;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
    endtask

    // Plays stim as one download; coinc drops ioctl_download together with the last strobe.
    task automatic send_stream(input bit coinc, input int max_gap);
        got_addr.delete(); got_data.delete(); got_cyc.delete(); strobe_cyc.delete();
        wait_cycles = 0;
        @(posedge clk); #1;
        ioctl_download = 1'b1;
        for (int i = 0; i < stim.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) @(posedge clk);
            drive_byte(stim[i], coinc && (i == stim.size() - 1));
        end
        if (ioctl_download) begin
            @(posedge clk); #1;
            ioctl_download = 1'b0;
        end
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        model_download();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dma_we, cpu_hold, busy, ioctl_wait, err_short, err_ovf} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {dma_we, cpu_hold, busy, ioctl_wait, err_short, err_ovf});
        end
        checks++;
        if ({dma_addr, dma_din, end_addr} !== 40'h0) begin
            errors++;
            $display("FAIL reset_buses: got addr=%h din=%h end=%h required zeros", dma_addr, dma_din, end_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        stim = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        send_stream(0, 2);
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d writes required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got %h=%h required %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
            if (exp_grp[i] == 0) begin
                checks++;
                if (got_cyc[i] != exp_cyc[i]) begin
                    errors++;
                    $display("FAIL basic_latency%0d: got cycle %0d required %0d", i, got_cyc[i], exp_cyc[i]);
                end
            end else if (i > 0 && exp_grp[i] == exp_grp[i-1]) begin
                checks++;
                if (got_cyc[i] - got_cyc[i-1] != 2) begin
                    errors++;
                    $display("FAIL basic_spacing%0d: got %0d cycles required 2", i, got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        checks++;
        if (end_addr !== 16'h0404 || err_ovf !== 1'b0 || err_short !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got end=%h ovf=%b short=%b required 0404 0 0", end_addr, err_ovf, err_short);
        end
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || wait_cycles == 0) begin
            errors++;
            $display("FAIL basic_release: got busy=%b hold=%b wait_cycles=%0d required 0 0 >0", busy, cpu_hold, wait_cycles);
        end
    endtask

    task automatic test_short();
        for (int n = 0; n < 2; n++) begin
            stim.delete();
            if (n == 1) stim.push_back(8'h01);
            send_stream(0, 1);
            checks++;
            if (err_short !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
                errors++;
                $display("FAIL short%0d_flags: got short=%b busy=%b hold=%b required 1 0 0", n, err_short, busy, cpu_hold);
            end
            checks++;
            if (got_addr.size() != 0 || end_addr !== exp_end) begin
                errors++;
                $display("FAIL short%0d_writes: got %0d writes end=%h required 0 writes end=%h", n, got_addr.size(), end_addr, exp_end);
            end
        end
    endtask

    task automatic test_overflow();
        stim = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(0, 0);
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL ovf_count: got %0d writes required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL ovf_write%0d: got %h=%h required %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (err_ovf !== 1'b1 || end_addr !== 16'h8000) begin
            errors++;
            $display("FAIL ovf_status: got ovf=%b end=%h required 1 8000", err_ovf, end_addr);
        end
    endtask

    task automatic test_empty();
        stim = '{8'h00, 8'h04};
        send_stream(0, 1);
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL empty_count: got %0d writes required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL empty_write%0d: got %h=%h required %h=%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (end_addr !== 16'h0400 || err_ovf !== 1'b0 || err_short !== 1'b0) begin
            errors++;
            $display("FAIL empty_status: got end=%h ovf=%b short=%b required 0400 0 0", end_addr, err_ovf, err_short);
        end
    endtask

    task automatic test_ignored_wr();
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 0);
        repeat (3) @(negedge clk);
        checks++;
        if (got_addr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wr: got %0d writes busy=%b required 0 writes busy=0", got_addr.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        got_addr.delete(); got_data.delete(); got_cyc.delete(); strobe_cyc.delete();
        @(posedge clk); #1;
        ioctl_download = 1'b1;
        stim = '{8'h00, 8'h10, 8'h11, 8'h22, 8'h33};
        foreach (stim[i]) drive_byte(stim[i], 0);
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dma_we !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0 || err_ovf !== 1'b0 || end_addr !== 16'h0) begin
            errors++;
            $display("FAIL midreset_state: got we=%b hold=%b busy=%b ovf=%b end=%h required 0 0 0 0 0000",
                     dma_we, cpu_hold, busy, err_ovf, end_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (got_addr.size() != 3 || (got_addr.size() == 3 && got_addr[2] !== 16'h1002)) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes required 3 ending at 1002", got_addr.size());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        last_end = 16'h0000;
        stim = '{8'h20, 8'h03, 8'h5A, 8'hA5};
        send_stream(0, 1);
        checks++;
        if (got_addr.size() != exp_addr.size() || end_addr !== exp_end || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_reload: got %0d writes end=%h busy=%b required %0d writes end=%h busy=0",
                     got_addr.size(), end_addr, busy, exp_addr.size(), exp_end);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [15:0] la;
            int n;
            bit coinc;
            case (it % 4)
                0: la = 16'($urandom_range(16'h7EFF, 16'h0400));
                1: la = 16'h7FF8 + 16'($urandom_range(7, 0));
                2: la = 16'hFFFA + 16'($urandom_range(5, 0));
                default: la = 16'($urandom);
            endcase
            n = $urandom_range(8, 0);
            coinc = (n > 0) && ($urandom_range(1, 0) == 1);
            stim = '{la[7:0], la[15:8]};
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
            send_stream(coinc, 2);
            checks++;
            if (got_addr.size() != exp_addr.size()) begin
                errors++;
                $display("FAIL rand%0d_count: la=%h n=%0d got %0d writes required %0d", it, la, n, got_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]
                    || (exp_grp[i] == 0 && got_cyc[i] != exp_cyc[i])) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: got %h=%h @%0d required %h=%h @%0d", it, i,
                             got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
                end
            end
            checks++;
            if (end_addr !== exp_end || err_ovf !== exp_ovf || err_short !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_status: got end=%h ovf=%b short=%b busy=%b required %h %b 0 0",
                         it, end_addr, err_ovf, err_short, busy, exp_end, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_overflow();
        test_empty();
        test_ignored_wr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
